// File: rtl/array_port_arbiter.sv
// ---------------------------------------------------------------------------
// array_port_arbiter
//
// Shares the single read/write port of a 128x108 lane-masked SRAM macro
// (4 write lanes of 27 bits) between two requesters. Round-robin arbitration
// with a valid/ready handshake is resolved combinationally in the request
// cycle. The memory port is driven in that same cycle, so the macro commits
// a write, or launches a read, on the grant edge. Read data comes back on a
// one-cycle response pulse to the requester that owned the read, in the
// cycle after the grant.
//
// Optional build macro: ARRAY_PORT_ARBITER_INIT_EN
//   defined   : after reset a zero-fill engine writes 0 to every address,
//               one per cycle. Requests are blocked until init_done_o rises,
//               128 cycles after reset release.
//   undefined : init_done_o is tied to 1. Arbitration starts on the first
//               cycle after reset release.
//
// Ports
//   clock_i          sole clock, rising edge
//   reset_i          asynchronous, active-high reset
//   reqN_valid_i     requester N request (N = 0, 1)
//   reqN_ready_o     requester N granted this cycle
//   reqN_write_i     1 = write, 0 = read
//   reqN_addr_i      word address
//   reqN_mask_i      write lane enables (ignored on reads)
//   reqN_wdata_i     write data
//   respN_valid_o    read data for requester N valid this cycle
//   respN_rdata_o    read data (0 unless respN_valid_o)
//   mem_en_o         memory enable
//   mem_wmode_o      memory write mode
//   mem_addr_o       memory address
//   mem_wmask_o      memory lane mask
//   mem_wdata_o      memory write data
//   mem_rdata_i      memory read data, valid the cycle after a read enable
//   init_done_o      array usable; requests are blocked while 0
// ---------------------------------------------------------------------------
module array_port_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 108,
    parameter int MASK_W = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic              req0_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [MASK_W-1:0] req0_mask_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    output logic              resp0_valid_o,
    output logic [DATA_W-1:0] resp0_rdata_o,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [MASK_W-1:0] req1_mask_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    output logic              resp1_valid_o,
    output logic [DATA_W-1:0] resp1_rdata_o,

    output logic              mem_en_o,
    output logic              mem_wmode_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [MASK_W-1:0] mem_wmask_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              init_done_o
);

    // Round-robin pointer: index of the requester favoured on contention.
    logic rr_ptr_q, rr_ptr_d;
    // Read issued last cycle; its data is on mem_rdata_i this cycle.
    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;

    logic              init_done;
    logic              init_busy;
    logic [ADDR_W-1:0] init_addr;

`ifdef ARRAY_PORT_ARBITER_INIT_EN
    // state   | meaning
    // ST_INIT | zero-filling the array, one address per cycle
    // ST_DONE | fill finished, arbitration enabled
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_DONE = 1'b1
    } init_state_t;

    init_state_t       state_q;
    logic [ADDR_W-1:0] init_cnt_q;
    logic              init_done_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    // Last address is being written on this edge.
                    if (&init_cnt_q) begin
                        state_q     <= ST_DONE;
                        init_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Gated by reset so the memory port stays idle while reset is held.
    assign init_busy = (state_q == ST_INIT) && !reset_i;
    assign init_addr = init_cnt_q;
    assign init_done = init_done_q;
`else
    assign init_busy = 1'b0;
    assign init_addr = '0;
    assign init_done = 1'b1;
`endif

    // Arbitration. Reset also blocks grants so that every handshake and
    // memory output reads 0 while reset is held, whatever the inputs do.
    logic arb_en;
    logic gnt0, gnt1;

    assign arb_en = init_done && !init_busy && !reset_i;
    assign gnt0   = arb_en && req0_valid_i && (!req1_valid_i || !rr_ptr_q);
    assign gnt1   = arb_en && req1_valid_i && (!req0_valid_i ||  rr_ptr_q);

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    // Memory port: unregistered so the macro samples the winner on the
    // grant edge itself.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_wmode_o = 1'b0;
        mem_addr_o  = '0;
        mem_wmask_o = '0;
        mem_wdata_o = '0;
        if (init_busy) begin
            mem_en_o    = 1'b1;
            mem_wmode_o = 1'b1;
            mem_addr_o  = init_addr;
            mem_wmask_o = '1;
            mem_wdata_o = '0;
        end else if (gnt0) begin
            mem_en_o    = 1'b1;
            mem_wmode_o = req0_write_i;
            mem_addr_o  = req0_addr_i;
            mem_wmask_o = req0_write_i ? req0_mask_i : '0;
            mem_wdata_o = req0_wdata_i;
        end else if (gnt1) begin
            mem_en_o    = 1'b1;
            mem_wmode_o = req1_write_i;
            mem_addr_o  = req1_addr_i;
            mem_wmask_o = req1_write_i ? req1_mask_i : '0;
            mem_wdata_o = req1_wdata_i;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt0) begin
            rr_ptr_d = 1'b1;
        end else if (gnt1) begin
            rr_ptr_d = 1'b0;
        end

        rd_pend_d  = (gnt0 && !req0_write_i) || (gnt1 && !req1_write_i);
        rd_owner_d = rd_owner_q;
        if (rd_pend_d) begin
            rd_owner_d = gnt1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q   <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Response: the macro's read data passes straight through to the owner.
    assign resp0_valid_o = rd_pend_q && !rd_owner_q;
    assign resp1_valid_o = rd_pend_q &&  rd_owner_q;
    assign resp0_rdata_o = resp0_valid_o ? mem_rdata_i : '0;
    assign resp1_rdata_o = resp1_valid_o ? mem_rdata_i : '0;

    assign init_done_o = init_done;

endmodule

// File: tb/tb_array_port_arbiter.sv
`timescale 1ns/1ps
module tb_array_port_arbiter;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 108;
    localparam int MASK_W = 4;
    localparam int LANE_W = 27;
    localparam int DEPTH  = 128;

    typedef struct {
        logic              v;
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [MASK_W-1:0] m;
        logic [DATA_W-1:0] d;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic              req0_valid, req0_ready, req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [MASK_W-1:0] req0_mask;
    logic [DATA_W-1:0] req0_wdata;
    logic              resp0_valid;
    logic [DATA_W-1:0] resp0_rdata;
    logic              req1_valid, req1_ready, req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [MASK_W-1:0] req1_mask;
    logic [DATA_W-1:0] req1_wdata;
    logic              resp1_valid;
    logic [DATA_W-1:0] resp1_rdata;
    logic              mem_en, mem_wmode;
    logic [ADDR_W-1:0] mem_addr;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              init_done;

    array_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
        .clock_i(clk), .reset_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_write_i(req0_write),
        .req0_addr_i(req0_addr), .req0_mask_i(req0_mask), .req0_wdata_i(req0_wdata),
        .resp0_valid_o(resp0_valid), .resp0_rdata_o(resp0_rdata),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_write_i(req1_write),
        .req1_addr_i(req1_addr), .req1_mask_i(req1_mask), .req1_wdata_i(req1_wdata),
        .resp1_valid_o(resp1_valid), .resp1_rdata_o(resp1_rdata),
        .mem_en_o(mem_en), .mem_wmode_o(mem_wmode), .mem_addr_o(mem_addr),
        .mem_wmask_o(mem_wmask), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .init_done_o(init_done)
    );

    always #5 clk = ~clk;

    // SRAM macro: lane-masked write, registered read.
    logic [DATA_W-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wmode) begin
                for (int l = 0; l < MASK_W; l++) begin
                    if (mem_wmask[l]) sram[mem_addr][l*LANE_W +: LANE_W] <= mem_wdata[l*LANE_W +: LANE_W];
                end
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    req_t              r [2];
    int                last_grant;
    bit                exp_rv [2];
    logic [DATA_W-1:0] exp_rd;
    int                init_left;
    int                gnt_log [$];
    logic              obs_rv [2];
    logic [DATA_W-1:0] obs_rd [2];
    int                total  = 0;
    int                errors = 0;

    localparam logic [DATA_W-1:0] DATA1    = 108'h123456789ABCDEF0123456789;
    localparam logic [DATA_W-1:0] LANE_EXP = {27'h7FFFFFF, 27'h0, 27'h7FFFFFF, 27'h0};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    function automatic req_t mk(input logic w, input logic [ADDR_W-1:0] a,
                                input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
        req_t t;
        t.v = 1'b1; t.w = w; t.a = a; t.m = m; t.d = d;
        return t;
    endfunction

    function automatic req_t idle();
        req_t t;
        t.v = 1'b0; t.w = 1'b0; t.a = '0; t.m = '0; t.d = '0;
        return t;
    endfunction

    task automatic drive();
        req0_valid = r[0].v; req0_write = r[0].w; req0_addr = r[0].a; req0_mask = r[0].m; req0_wdata = r[0].d;
        req1_valid = r[1].v; req1_write = r[1].w; req1_addr = r[1].a; req1_mask = r[1].m; req1_wdata = r[1].d;
    endtask

    // One clock cycle: drive at negedge, check, advance model at posedge,
    // return at the next negedge.
    task automatic step();
        int win;
        drive();
        #1;
        win = -1;
        if (init_left == 0) begin
            // On contention the requester that did not win last time goes.
            if (r[0].v && r[1].v) win = 1 - last_grant;
            else if (r[0].v)      win = 0;
            else if (r[1].v)      win = 1;
        end
        check("ready0", req0_ready, win == 0);
        check("ready1", req1_ready, win == 1);
        check("init_done", init_done, init_left == 0);
        if (init_left > 0) begin
            check("init_en", mem_en, 1);
            check("init_wmode", mem_wmode, 1);
            check("init_addr", mem_addr, DEPTH - init_left);
            check("init_wmask", mem_wmask, 4'hF);
            check("init_wdata", mem_wdata, 0);
        end else if (win >= 0) begin
            check("mem_en", mem_en, 1);
            check("mem_wmode", mem_wmode, r[win].w);
            check("mem_addr", mem_addr, r[win].a);
            check("mem_wmask", mem_wmask, r[win].w ? r[win].m : 4'h0);
            check("mem_wdata", mem_wdata, r[win].d);
        end else begin
            check("idle_en", mem_en, 0);
            check("idle_wmode", mem_wmode, 0);
            check("idle_addr", mem_addr, 0);
            check("idle_wmask", mem_wmask, 0);
            check("idle_wdata", mem_wdata, 0);
        end
        obs_rv[0] = resp0_valid; obs_rd[0] = resp0_rdata;
        obs_rv[1] = resp1_valid; obs_rd[1] = resp1_rdata;
        check("resp0_valid", resp0_valid, exp_rv[0]);
        check("resp1_valid", resp1_valid, exp_rv[1]);
        check("resp0_rdata", resp0_rdata, exp_rv[0] ? exp_rd : '0);
        check("resp1_rdata", resp1_rdata, exp_rv[1] ? exp_rd : '0);
        @(posedge clk);
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        if (init_left > 0) begin
            ref_mem[DEPTH - init_left] = '0;
            init_left--;
        end else if (win >= 0) begin
            last_grant = win;
            gnt_log.push_back(win);
            if (r[win].w) begin
                for (int l = 0; l < MASK_W; l++)
                    if (r[win].m[l]) ref_mem[r[win].a][l*LANE_W +: LANE_W] = r[win].d[l*LANE_W +: LANE_W];
            end else begin
                exp_rv[win] = 1'b1;
                exp_rd      = ref_mem[r[win].a];
            end
            r[win].v = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        r[0] = idle();
        r[1] = idle();
        drive();
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_resp0_valid", resp0_valid, 0);
        check("rst_resp1_valid", resp1_valid, 0);
        check("rst_resp0_rdata", resp0_rdata, 0);
        check("rst_resp1_rdata", resp1_rdata, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wmode", mem_wmode, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        check("rst_mem_wdata", mem_wdata, 0);
`ifdef ARRAY_PORT_ARBITER_INIT_EN
        check("rst_init_done", init_done, 0);
        init_left = DEPTH;
`else
        check("rst_init_done", init_done, 1);
        init_left = 0;
`endif
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        last_grant = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_init();
        while (init_left > 0) step();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = rand_data();
            ref_mem[i] = sram[i];
        end
        r[0] = idle();
        r[1] = idle();
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        exp_rd = '0;
        last_grant = 1;
        init_left = 0;
        drive();
        @(negedge clk);
        apply_reset();

`ifdef ARRAY_PORT_ARBITER_INIT_EN
        // Read of 0x7F held through the whole zero fill.
        r[0] = mk(1'b0, 7'h7F, 4'h0, '0);
        wait_init();
        step();
        step();
        check("init_rd7f_valid", obs_rv[0], 1);
        check("init_rd7f_data", obs_rd[0], 0);
`else
        wait_init();
`endif

        // Write then read
        r[0] = mk(1'b1, 7'h05, 4'hF, DATA1);
        step();
        r[0] = mk(1'b0, 7'h05, 4'h0, '0);
        step();
        step();
        check("wr_rd_valid", obs_rv[0], 1);
        check("wr_rd_data", obs_rd[0], DATA1);
        check("wr_rd_resp1_quiet", obs_rv[1], 0);
        step();
        check("wr_rd_single_pulse", obs_rv[0], 0);

        // Lane mask
        r[0] = mk(1'b1, 7'h10, 4'hF, '1);
        step();
        r[0] = mk(1'b1, 7'h10, 4'b0101, '0);
        step();
        r[0] = mk(1'b0, 7'h10, 4'h0, '0);
        step();
        step();
        check("lane_mask_valid", obs_rv[0], 1);
        check("lane_mask_data", obs_rd[0], LANE_EXP);

        // Reset in the cycle after a read grant
        r[1] = mk(1'b0, 7'h05, 4'h0, '0);
        step();
        apply_reset();
        wait_init();
        step();
        check("rst_mid_no_resp0", obs_rv[0], 0);
        check("rst_mid_no_resp1", obs_rv[1], 0);

        // Contention straight after reset
        gnt_log.delete();
        for (int i = 0; i < 6; i++) begin
            if (!r[0].v) r[0] = mk(1'b0, 7'(i), 4'h0, '0);
            if (!r[1].v) r[1] = mk(1'b0, 7'(i + 32), 4'h0, '0);
            step();
        end
        step();
        step();
        for (int i = 0; i < 6; i++)
            check($sformatf("contend_gnt%0d", i), (gnt_log.size() > i) ? gnt_log[i] : -1, i % 2);

        // Lone requester 1, then contention goes to requester 0
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            r[1] = mk(1'b0, 7'(i + 64), 4'h0, '0);
            step();
        end
        r[0] = mk(1'b0, 7'h05, 4'h0, '0);
        r[1] = mk(1'b0, 7'h06, 4'h0, '0);
        step();
        step();
        step();
        for (int i = 0; i < 4; i++)
            check($sformatf("lone_gnt%0d", i), (gnt_log.size() > i) ? gnt_log[i] : -1, 1);
        check("lone_then_req0", (gnt_log.size() > 4) ? gnt_log[4] : -1, 0);

        // Random traffic on a small address window to exercise RAW hazards
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!r[i].v && $urandom_range(0, 3) != 0)
                    r[i] = mk(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)),
                              4'($urandom_range(0, 15)), rand_data());
            end
            step();
        end
        r[0] = idle();
        r[1] = idle();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end
endmodule

// File: doc/array_port_arbiter.md
Name: array_port_arbiter

Overview:
- Shares the single read/write port of a 128x108 lane-masked SRAM macro (4 write lanes of 27 bits) between two requesters.
- Round-robin arbitration with a valid/ready request handshake.
- Read data is returned on a per-requester response pulse one cycle after the grant.
- Sits between the two requesting pipelines and the memory wrapper; drives the memory's addr/en/wmode/wmask/wdata and consumes its rdata.

Parameters:
- ADDR_W, 7, address width (depth = 2^ADDR_W = 128)
- DATA_W, 108, data width
- MASK_W, 4, write-lane count; lane width = DATA_W/MASK_W = 27

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 request
- req0_ready  out  1  requester 0 granted this cycle
- req0_write  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_W  address
- req0_mask  in  MASK_W  write lane enables, ignored on reads
- req0_wdata  in  DATA_W  write data
- resp0_valid  out  1  read data for requester 0 valid this cycle
- resp0_rdata  out  DATA_W  read data
- req1_*, resp1_*  same set of ports as requester 0, for requester 1
- mem_en  out  1  memory enable
- mem_wmode  out  1  memory write mode
- mem_addr  out  ADDR_W  memory address
- mem_wmask  out  MASK_W  memory lane mask
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read enable
- init_done  out  1  array usable; requests are blocked while 0

Behaviour:
- Reset values:
  - rr_ptr = 0
  - rd_pend = 0, rd_owner = 0
  - all ready/valid outputs = 0
  - mem_en = 0
  - init_done per the optional feature
- Arbitration (combinational, same cycle), only when init_done = 1:
  - one valid: that requester wins
  - both valid: the requester selected by rr_ptr wins
  - winner: reqN_ready = 1; loser ready = 0
  - ready never asserts without the matching valid
- A request transfers when valid and ready are both 1.
- Requester obligations: hold addr/write/mask/wdata stable and keep valid high until the transfer.
- Port drive on a grant:
  - mem_en = 1
  - mem_wmode, mem_addr, mem_wmask, mem_wdata taken from the winner
  - mem_wmask is forced to 0 on reads
- Port drive with no grant: mem_en = 0; address/data are don't-care and held at 0.
- rr_ptr update:
  - on any grant, rr_ptr <= index of the loser, i.e. NOT winner
  - unchanged when there is no grant
  - a lone requester may be granted every cycle
- Read return:
  - on a read grant: rd_pend <= 1, rd_owner <= winner; otherwise rd_pend <= 0
  - next cycle: respN_valid = rd_pend && rd_owner==N, for exactly one cycle
  - respN_rdata = mem_rdata, unregistered
  - the non-owner's rdata is driven to 0
  - no response backpressure; the consumer must capture the pulse
- Writes produce no response. Write-to-read ordering is the grant order.
- Back-to-back: a new grant may issue in the same cycle a response returns (full throughput: 1 access/cycle).
- Read-after-write to the same address in consecutive grants returns the new data, because the memory commits the write at the grant edge.
- Reset asserted mid-operation: clears the pending response immediately (asynchronous) with no response issued; any in-flight write is allowed to land or be lost, undefined.

Optional Feature:
- Macro: ARRAY_PORT_ARBITER_INIT_EN.
- Defined (zero-fill engine):
  - FSM states: INIT -> DONE; reset enters INIT with counter = 0 and init_done = 0.
  - INIT: each cycle drive mem_en = 1, mem_wmode = 1, mem_wmask = all ones, mem_wdata = 0, mem_addr = counter; counter++.
  - After address 127 is written, go to DONE and init_done <= 1 (128 cycles after reset release).
  - Requester ready = 0 throughout INIT.
  - Reset during INIT restarts at address 0.
- Undefined: no FSM; init_done is tied to 1 and arbitration starts on the first cycle after reset release.

Test Plan:
- Write then read: req0 write addr 0x05, mask 0xF, data 0x123456789ABCDEF0123456789 -> ready0 the same cycle; req0 read addr 0x05 -> resp0_valid exactly 1 cycle after the grant with that data; resp1_valid stays 0.
- Lane mask: write all-ones to 0x10, then write 0 with mask 0b0101 -> readback = lanes 3 and 1 all-ones, lanes 2 and 0 zero (0x7FFFFFF_0000000_7FFFFFF_0000000).
- Contention: both valid with reads for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with 0 after reset; responses alternate with matching owners.
- Lone requester: only req1 valid for 4 cycles -> 4 consecutive grants; rr_ptr = 0 afterwards, so simultaneous valids next go to req0.
- Reset mid-read: assert reset in the cycle after a read grant -> no respN_valid pulse, and all outputs 0 while reset is held.
- With ARRAY_PORT_ARBITER_INIT_EN defined: release reset -> 128 zero writes to addresses 0..127 with ready held 0; init_done rises at cycle 128; a read of 0x7F then returns 0.
